// File: rtl/moore_seq_pkg.sv
// moore_seq_pkg: state encoding and shared constants for the 1010 sequence generator
package moore_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAP  = 3'd1,
    ST_S1A  = 3'd2,
    ST_S0A  = 3'd3,
    ST_S1B  = 3'd4,
    ST_S0B  = 3'd5,
    ST_DONE = 3'd6
  } state_t;
  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;
  localparam int   PAT_W     = 4;
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter with zero flag that saturates at zero
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         zero
);
  always_ff @(posedge Clk)
    if (!Rst) q <= '0;
    else if (load) q <= d;
    else if (dec && !zero) q <= q - 1'b1;
  assign zero = q == '0;
endmodule

// File: rtl/moore_1010_seq_gen.sv
// moore_1010_seq_gen: Moore serial transmitter of GAP zeros followed by Count 1010 repetitions
module moore_1010_seq_gen
  import moore_seq_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Mode,
  input  logic [CNT_W-1:0] Count,
  output logic             Out,
  output logic             Valid,
  output logic             Busy,
  output logic             Done,
  output logic [2:0]       CS
);
  localparam logic [3:0] GAP_INIT = 4'(GAP - 1);
  state_t cs, ns;
  logic mode_q, load, gap_dec, rep_dec, gap_zero, rep_zero;
  logic [3:0] gap_cnt;
  logic [CNT_W-1:0] rep_cnt;
  seq_down_counter #(.W(4)) u_gap (
    .Clk(Clk), .Rst(Rst), .load(load), .dec(gap_dec), .d(GAP_INIT), .q(gap_cnt), .zero(gap_zero)
  );
  seq_down_counter #(.W(CNT_W)) u_rep (
    .Clk(Clk), .Rst(Rst), .load(load), .dec(rep_dec), .d(Count), .q(rep_cnt), .zero(rep_zero)
  );
  always_ff @(posedge Clk)
    if (!Rst) begin
      cs     <= ST_IDLE;
      mode_q <= MODE_NOVL;
    end else begin
      cs <= ns;
      if (load) mode_q <= Mode;
    end
  always_comb begin
    ns      = ST_IDLE;
    load    = 1'b0;
    gap_dec = 1'b0;
    rep_dec = 1'b0;
    case (cs)
      ST_IDLE: begin
        load = Start;
        ns   = Start ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        gap_dec = !gap_zero;
        ns      = !gap_zero ? ST_GAP : rep_zero ? ST_DONE : ST_S1A;
      end
      ST_S1A: ns = ST_S0A;
      ST_S0A: ns = ST_S1B;
      ST_S1B: ns = ST_S0B;
      ST_S0B: begin
        rep_dec = 1'b1;
        ns      = rep_cnt == CNT_W'(1) ? ST_DONE : mode_q == MODE_OVL ? ST_S1B : ST_S1A;
      end
      default: ns = ST_IDLE;
    endcase
  end
  assign Out   = cs == ST_S1A || cs == ST_S1B;
  assign Valid = cs inside {ST_GAP, ST_S1A, ST_S0A, ST_S1B, ST_S0B};
  assign Busy  = cs != ST_IDLE;
  assign Done  = cs == ST_DONE;
  assign CS    = cs;
  // the gap counter is only ever loaded with GAP-1 and counts down from there
  a_gap_range: assert property (@(posedge Clk) gap_cnt <= GAP_INIT);
endmodule

// File: tb/tb_moore_1010_seq_gen.sv
// tb_moore_1010_seq_gen: randomized and directed checks against a frame-queue model
module tb_moore_1010_seq_gen;
  localparam int CNT_W = 4;
  localparam int GAP   = 2;
  logic Clk = 0, Rst = 0, Start = 0, Mode = 0;
  logic [CNT_W-1:0] Count = '0;
  logic Out, Valid, Busy, Done;
  logic [2:0] CS;
  int total = 0, bad = 0;
  int q[$];
  int frame_hits = 0, frame_mode = 0, hits = 0, hn = 0, e;
  logic [3:0] sh = '0, shn = '0;
  logic [63:0] bits;
  int nv, dat;
  always #5 Clk = ~Clk;
  moore_1010_seq_gen #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode), .Count(Count),
    .Out(Out), .Valid(Valid), .Busy(Busy), .Done(Done), .CS(CS)
  );
  task automatic chk(input string n, input int a, input int x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, x);
    end
  endtask
  // model: queue of the state codes a whole accepted frame walks through
  always @(posedge Clk) begin
    if (!Rst) q.delete();
    else if (q.size() != 0) void'(q.pop_front());
    else if (Start) begin
      for (int g = 0; g < GAP; g++) q.push_back(1);
      for (int r = 0; r < int'(Count); r++) begin
        if (r == 0 || !Mode) begin q.push_back(2); q.push_back(3); end
        q.push_back(4); q.push_back(5);
      end
      q.push_back(6);
      frame_hits = int'(Count);
      frame_mode = int'(Mode);
    end
  end
  always @(negedge Clk) begin
    e = q.size() != 0 ? q[0] : 0;
    chk("cs", int'(CS), e);
    chk("out", int'(Out), int'(e == 2 || e == 4));
    chk("valid", int'(Valid), int'(e >= 1 && e <= 5));
    chk("busy", int'(Busy), int'(e != 0));
    chk("done", int'(Done), int'(e == 6));
    if (!Busy) begin sh = '0; shn = '0; hits = 0; hn = 0; end
    else if (Valid) begin
      sh = {sh[2:0], Out};
      if (sh == 4'b1010) hits++;
      shn = {shn[2:0], Out};
      if (shn == 4'b1010) begin hn++; shn = '0; end
    end
    if (Done) chk(frame_mode != 0 ? "hits_ovl" : "hits_novl", frame_mode != 0 ? hits : hn, frame_hits);
  end
  task automatic run_frame(input logic m, input logic [CNT_W-1:0] c, input int poke,
                           output logic [63:0] b, output int n, output int d);
    b = '0; n = 0; d = -1;
    @(negedge Clk);
    Start = 1; Mode = m; Count = c;
    for (int i = 1; i <= 100; i++) begin
      @(negedge Clk);
      Start = i == poke;
      if (i == 2) begin Mode = ~m; Count = ~c; end
      if (Valid) begin b = {b[62:0], Out}; n++; end
      if (Done) begin d = i; break; end
    end
    Start = 0;
  endtask
  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_cs", int'(CS), 0);
    chk("rst_busy", int'(Busy), 0);
    Rst = 1;
    repeat (3) @(negedge Clk);
    chk("idle_cs", int'(CS), 0);
    chk("idle_valid", int'(Valid), 0);
    run_frame(0, 2, 0, bits, nv, dat);
    chk("novl_bits", int'(bits[31:0]), 'b0010101010);
    chk("novl_nv", nv, 10);
    chk("novl_done", dat, 11);
    run_frame(1, 3, 0, bits, nv, dat);
    chk("ovl_bits", int'(bits[31:0]), 'b0010101010);
    chk("ovl_nv", nv, 10);
    chk("ovl_done", dat, 11);
    run_frame(0, 0, 2, bits, nv, dat);
    chk("cnt0_bits", int'(bits[31:0]), 0);
    chk("cnt0_nv", nv, 2);
    chk("cnt0_done", dat, 3);
    run_frame(0, 2, 5, bits, nv, dat);
    chk("busy_start_nv", nv, 10);
    chk("busy_start_done", dat, 11);
    @(negedge Clk);
    Start = 1; Mode = 0; Count = 2;
    @(negedge Clk);
    Start = 0;
    for (int i = 0; i < 10 && CS != 3'd4; i++) @(negedge Clk);
    chk("reach_s1b", int'(CS), 4);
    Rst = 0;
    @(negedge Clk);
    chk("midrst_cs", int'(CS), 0);
    chk("midrst_done", int'(Done), 0);
    chk("midrst_out", int'(Out), 0);
    Rst = 1;
    run_frame(0, 2, 0, bits, nv, dat);
    chk("after_rst_nv", nv, 10);
    chk("after_rst_done", dat, 11);
    run_frame(0, 15, 0, bits, nv, dat);
    chk("max_nv", nv, 62);
    chk("max_done", dat, 63);
    @(negedge Clk);
    Start = 1; Mode = 1; Count = 1;
    dat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (Done) begin dat = i; break; end
    end
    chk("held_done", dat, 7);
    @(negedge Clk);
    chk("held_idle", int'(CS), 0);
    @(negedge Clk);
    chk("held_gap", int'(CS), 1);
    Start = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge Clk);
      Rst = $urandom_range(0, 99) != 0;
      Start = $urandom_range(0, 3) == 0;
      Mode = 1'($urandom);
      Count = CNT_W'($urandom);
    end
    Rst = 1; Start = 0;
    repeat (80) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
